uplus_rx_frame_filter: RTL

Receive-side frame filter and packet buffer placed after each `uplus_ten_gig_channel` RX port, in the channel's RX clock domain. It accepts the MAC's non-backpressured `rx_axis` stream and stores frames in a packet FIFO. Only frames that are error-free and within `[P_MIN_LENGTH, P_MAX_LENGTH]` bytes are committed. Committed frames are presented to user logic on a standard AXI-Stream master with `tready`; rejected frames leave no trace on the output.

---
 rtl/uplus_eth_pkg.sv | 21 ++
 rtl/uplus_sdp_ram.sv | 23 ++
 rtl/uplus_rx_frame_filter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/uplus_eth_pkg.sv
// Shared RX-path definitions: stored beat word layout, write-side FSM states and byte counting.
package uplus_eth_pkg;

  // Stored beat word: {tlast, tkeep[7:0], tdata[63:0]}
  localparam int BEAT_W = 73;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_IDLE = 2'd1,
    ST_RECV = 2'd2,
    ST_DROP = 2'd3
  } wr_state_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/uplus_sdp_ram.sv
// Simple dual-port RAM, one write and one read port; read data registered one cycle after rd_en.
// rd_data holds its value while rd_en is low, so it can act as a one-entry prefetch stage.
module uplus_sdp_ram #(
  parameter int WIDTH = 73,
  parameter int DEPTH = 2048,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/uplus_rx_frame_filter.sv
// RX frame filter: buffers MAC beats, commits only clean frames of legal length, replays them on AXI-Stream.
// First output beat 2 cycles after a good tlast; input cannot stall, overflow drops the frame. RX_FILTER_STATS_EN adds counters.
module uplus_rx_frame_filter
  import uplus_eth_pkg::*;
#(
  parameter int P_MIN_LENGTH = 64,
  parameter int P_MAX_LENGTH = 9600,
  parameter int P_DEPTH      = 2048
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        s_axis_tvalid,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic        o_frame_drop
`ifdef RX_FILTER_STATS_EN
  ,
  output logic [31:0] o_good_cnt,
  output logic [31:0] o_err_cnt,
  output logic [31:0] o_ovf_cnt
`endif
);
  localparam int AW = $clog2(P_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(P_DEPTH);
  localparam logic [15:0]   MIN_LEN = 16'(P_MIN_LENGTH);
  localparam logic [15:0]   MAX_LEN = 16'(P_MAX_LENGTH);
  localparam logic [16:0]   CNT_SAT = 17'(P_MAX_LENGTH + 1);

  wr_state_t         state, state_nxt;
  logic [PW-1:0]     wr_ptr, wr_ptr_nxt, wr_commit, commit_nxt, rd_ptr;
  logic [15:0]       cnt, cnt_nxt, beat_cnt;
  logic [16:0]       sum;
  logic              err, err_nxt, beat_err, frame_bad, full;
  logic              we, drop_nxt, good_evt, err_evt, ovf_evt;
  logic              avail, move, re, ram_vld;
  logic [BEAT_W-1:0] rd_word;

  assign full = (wr_ptr - rd_ptr) == DEPTH_P;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_SYNC;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    commit_nxt = wr_commit;
    cnt_nxt    = cnt;
    err_nxt    = err;
    we         = 1'b0;
    drop_nxt   = 1'b0;
    good_evt   = 1'b0;
    err_evt    = 1'b0;
    ovf_evt    = 1'b0;
    // A beat in IDLE starts a fresh frame, so the running totals only carry in RECV.
    sum       = ((state == ST_RECV) ? {1'b0, cnt} : 17'd0) + {13'd0, popcount8(s_axis_tkeep)};
    beat_cnt  = (sum > CNT_SAT) ? CNT_SAT[15:0] : sum[15:0];
    beat_err  = ((state == ST_RECV) && err) || (!s_axis_tlast && (s_axis_tkeep != 8'hFF));
    frame_bad = s_axis_tuser || (beat_cnt < MIN_LEN) || (beat_cnt > MAX_LEN) || beat_err;
    if (s_axis_tvalid) begin
      case (state)
        ST_SYNC: if (s_axis_tlast) state_nxt = ST_IDLE;
        ST_DROP: begin
          if (s_axis_tlast) begin
            state_nxt = ST_IDLE;
            drop_nxt  = 1'b1;
            ovf_evt   = 1'b1;
          end
        end
        default: begin
          if (full) begin
            wr_ptr_nxt = wr_commit;
            if (s_axis_tlast) begin
              state_nxt = ST_IDLE;
              drop_nxt  = 1'b1;
              ovf_evt   = 1'b1;
            end else begin
              state_nxt = ST_DROP;
            end
          end else begin
            we         = 1'b1;
            wr_ptr_nxt = wr_ptr + PW'(1);
            cnt_nxt    = beat_cnt;
            err_nxt    = beat_err;
            if (s_axis_tlast) begin
              state_nxt = ST_IDLE;
              if (frame_bad) begin
                wr_ptr_nxt = wr_commit;
                drop_nxt   = 1'b1;
                err_evt    = 1'b1;
              end else begin
                commit_nxt = wr_ptr + PW'(1);
                good_evt   = 1'b1;
              end
            end else begin
              state_nxt = ST_RECV;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr       <= '0;
      wr_commit    <= '0;
      cnt          <= '0;
      err          <= 1'b0;
      o_frame_drop <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      wr_commit    <= commit_nxt;
      cnt          <= cnt_nxt;
      err          <= err_nxt;
      o_frame_drop <= drop_nxt;
    end
  end

  uplus_sdp_ram #(
    .WIDTH (BEAT_W),
    .DEPTH (P_DEPTH)
  ) u_ram (
    .clk     (i_clk),
    .wr_en   (we),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
    .rd_en   (re),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_word)
  );

  // RAM output register is the prefetch slot; refill it whenever it is empty or draining.
  assign avail = rd_ptr != wr_commit;
  assign move  = ram_vld && (!m_axis_tvalid || m_axis_tready);
  assign re    = avail && (!ram_vld || move);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr        <= '0;
      ram_vld       <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (re) rd_ptr <= rd_ptr + PW'(1);
      ram_vld <= re || (ram_vld && !move);
      if (move) begin
        m_axis_tvalid <= 1'b1;
        {m_axis_tlast, m_axis_tkeep, m_axis_tdata} <= rd_word;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

`ifdef RX_FILTER_STATS_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_good_cnt <= '0;
      o_err_cnt  <= '0;
      o_ovf_cnt  <= '0;
    end else begin
      if (good_evt) o_good_cnt <= o_good_cnt + 32'd1;
      if (err_evt)  o_err_cnt  <= o_err_cnt + 32'd1;
      if (ovf_evt)  o_ovf_cnt  <= o_ovf_cnt + 32'd1;
    end
  end
`else
  logic unused_stats;
  assign unused_stats = good_evt ^ err_evt ^ ovf_evt;
`endif

endmodule
